// File: rtl/spi_master_if.sv
// Byte handshake, receive path and SPI pins for spi_master.
// The master modport is the controller's view; the slave modport is the view
// of whatever drives bytes in and watches the pins.
interface spi_master_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       SSEL;

  modport master (
    input  tx_valid, tx_data, tx_last, MISO,
    output tx_ready, rx_valid, rx_data, busy, SCK, MOSI, SSEL
  );

  modport slave (
    output tx_valid, tx_data, tx_last, MISO,
    input  tx_ready, rx_valid, rx_data, busy, SCK, MOSI, SSEL
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master (CPOL=0, CPHA=0). Bytes arrive over valid/ready and go out
// MSB first; SSEL stays low across bytes until one tagged tx_last finishes,
// followed by a HOLD half-period and a GAP half-period with SSEL high.
// Every output is a register.
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t           r_state, w_state;
  logic [DIV_W-1:0] r_div, w_div;
  logic [3:0]       r_bit, w_bit;
  logic             r_sck, w_sck;
  logic             r_mosi, w_mosi;
  logic             r_ssel, w_ssel;
  logic             r_ready, w_ready;
  logic             r_rx_valid, w_rx_valid;
  logic             r_busy, w_busy;
  logic             r_last, w_last;
  logic [7:0]       r_rx_data, w_rx_data;
  logic [7:0]       r_rx_sh, w_rx_sh;
  logic [6:0]       r_tx_sh, w_tx_sh;
  logic             w_half_end;
  logic             w_accept;

  assign w_half_end = (r_div == DIV_MAX);
  assign w_accept   = r_ready && bus.tx_valid;

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    w_state    = r_state;
    w_div      = r_div;
    w_bit      = r_bit;
    w_sck      = r_sck;
    w_mosi     = r_mosi;
    w_ssel     = r_ssel;
    w_ready    = r_ready;
    w_rx_valid = 1'b0;
    w_busy     = r_busy;
    w_last     = r_last;
    w_rx_data  = r_rx_data;
    w_rx_sh    = r_rx_sh;
    w_tx_sh    = r_tx_sh;

    unique case (r_state)
      S_IDLE, S_WAIT: begin
        // Divider parked at zero so each byte gets a full setup half-period.
        w_div   = '0;
        w_ready = 1'b1;
        w_sck   = 1'b0;
        if (r_state == S_IDLE) begin
          w_ssel = 1'b1;
          w_mosi = 1'b0;
        end
        if (w_accept) begin
          w_state = S_SHIFT;
          w_ready = 1'b0;
          w_busy  = 1'b1;
          w_ssel  = 1'b0;
          w_bit   = '0;
          w_mosi  = bus.tx_data[7];
          w_tx_sh = bus.tx_data[6:0];
          w_last  = bus.tx_last;
        end
      end

      S_SHIFT: begin
        if (w_half_end) begin
          w_div = '0;
          w_bit = r_bit + 4'd1;
          if (!r_bit[0]) begin
            // End of a low half: SCK rises and MISO is captured on the same edge.
            w_sck   = 1'b1;
            w_rx_sh = {r_rx_sh[6:0], bus.MISO};
          end else begin
            w_sck = 1'b0;
            if (r_bit == 4'd15) begin
              w_rx_valid = 1'b1;
              w_rx_data  = r_rx_sh;
              if (r_last) begin
                w_state = S_HOLD;
                w_ready = 1'b0;
              end else begin
                w_state = S_WAIT;
                w_ready = 1'b1;
              end
            end else begin
              w_mosi  = r_tx_sh[6];
              w_tx_sh = {r_tx_sh[5:0], 1'b0};
            end
          end
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (w_half_end) begin
          w_state = S_GAP;
          w_div   = '0;
          w_ssel  = 1'b1;
          w_mosi  = 1'b0;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      S_GAP: begin
        if (w_half_end) begin
          w_state = S_IDLE;
          w_div   = '0;
          w_busy  = 1'b0;
          w_ready = 1'b1;
        end else begin
          w_div = r_div + DIV_W'(1);
        end
      end

      default: begin
        w_state = S_IDLE;
        w_div   = '0;
        w_ssel  = 1'b1;
        w_sck   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_ssel     <= 1'b1;
      r_ready    <= 1'b0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_last     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_sh    <= '0;
      r_tx_sh    <= '0;
    end else begin
      r_state    <= w_state;
      r_div      <= w_div;
      r_bit      <= w_bit;
      r_sck      <= w_sck;
      r_mosi     <= w_mosi;
      r_ssel     <= w_ssel;
      r_ready    <= w_ready;
      r_rx_valid <= w_rx_valid;
      r_busy     <= w_busy;
      r_last     <= w_last;
      r_rx_data  <= w_rx_data;
      r_rx_sh    <= w_rx_sh;
      r_tx_sh    <= w_tx_sh;
    end
  end

  assign bus.tx_ready = r_ready;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
  assign bus.busy     = r_busy;
  assign bus.SCK      = r_sck;
  assign bus.MOSI     = r_mosi;
  assign bus.SSEL     = r_ssel;

endmodule
